vend_ctrl: RTL
==============

// Module: vend_ctrl
// PURPOSE
//  Coin-accepting controller of the vending machine; the stage directly upstream of drinkouter.
//  Accumulates coin credit in half-yuan units and, once credit >= PRICE, enables drinkouter.
//  Waits for drinkouter's active-low finish pulse, then pays out change one half-unit at a time.
//  Also handles cancel (full refund) and a dispense timeout (refund of the price).
// PARAMETERS
//  PRICE       5     drink price in half-yuan units (5 = 2.5 yuan); must be >= 1
//  CREDIT_W    4     credit register width; must hold PRICE+2 (max credit ever reached)
//  TIMEOUT_CYC 1000  sclk cycles to wait for drink_out_fin before declaring a fault
// PORTS
//  sclk          in   1         system clock, rising edge
//  srst          in   1         reset; asynchronous, active-high
//  coin_half     in   1         1-cycle pulse: 0.5 yuan inserted (+1 unit)
//  coin_one      in   1         1-cycle pulse: 1 yuan inserted (+2 units)
//  cancel        in   1         1-cycle pulse: refund all credit
//  drink_out_fin in   1         from drinkouter; active-low 1-cycle pulse = drink delivered
//  drink_en      out  1         to drinkouter en; high for the whole dispense
//  change_half   out  1         1-cycle pulse per 0.5 yuan of change returned
//  coin_reject   out  1         1-cycle pulse: coin arrived while not accepting; coin is returned
//  fault         out  1         1-cycle pulse: dispense timed out
//  credit        out  CREDIT_W  current credit, half-yuan units
//  busy          out  1         high in DISPENSE or CHANGE
// BEHAVIOUR
//  - Reset (async, while srst=1): state IDLE; credit=0; all 1-bit outputs 0; timeout counter 0.
//  - All outputs are registered. Inputs are sampled on the rising edge of sclk.
//  - States and transitions:
//    IDLE:     no credit. Any coin adds its value and moves to COLLECT on the next edge.
//    COLLECT:  coin_half adds 1; coin_one adds 2; both in the same cycle add 3.
//              Each edge, registered credit >= PRICE -> DISPENSE: credit <= credit-PRICE, drink_en <= 1.
//              Threshold is checked on registered credit: there is 1 cycle from the last coin to drink_en.
//              cancel (credit > 0) -> CHANGE. cancel wins over a same-cycle coin; that coin -> coin_reject.
//    DISPENSE: drink_en held 1. drink_out_fin sampled 0 -> drink_en <= 0; goes to CHANGE if credit > 0, else IDLE.
//              Timeout counter increments every cycle. At TIMEOUT_CYC -> drink_en <= 0, fault pulse,
//              credit <= credit+PRICE, go to CHANGE. drink_out_fin and timeout on the same edge: fin wins.
//              cancel is ignored.
//    CHANGE:   change_half pulses high 1 cycle, then low 1 cycle. Each pulse decrements credit.
//              After the final pulse (credit reaches 0) -> IDLE. cancel is ignored.
//  - In DISPENSE and CHANGE every coin produces coin_reject the next cycle. Credit is unchanged.
//  - Credit never exceeds PRICE+2, so there is no overflow path. drink_out_fin outside DISPENSE is ignored.
//  - Timeout counter width is clog2(TIMEOUT_CYC+1). It clears on entry to DISPENSE.
//  - Reset mid-operation: drink_en drops immediately and credit is lost (no refund).
// TESTING (PRICE=5)
//  1. coin_one x3 -> credit 2,4,6; 1 cycle later drink_en=1, credit=1.
//     Then drink_out_fin=0 for 1 cycle -> drink_en=0, one change_half pulse, credit=0, IDLE.
//  2. coin_one, coin_one, coin_half -> drink_en=1 with credit=0; after fin -> IDLE with no change_half.
//  3. coin_one, coin_half, cancel -> 3 change_half pulses 2 cycles apart; drink_en never rises; credit=0.
//  4. credit=4, then coin_half+coin_one in the same cycle -> credit 7, dispense, credit 2.
//     A coin_one during DISPENSE -> coin_reject and credit stays 2. After fin -> 2 change_half pulses.
//  5. Dispense with fin held 1 for TIMEOUT_CYC cycles -> fault pulse, drink_en=0, change_half x5 (credit 5).
//  6. srst=1 mid-DISPENSE -> drink_en=0 with no clock edge and credit=0.
//     After release: coin_half -> COLLECT with credit 1.

Source files
------------

// File: rtl/vend_ctrl_if.sv
// Coin/dispense handshake bundle between the coin front end, vend_ctrl and drinkouter.
interface vend_ctrl_if #(
    parameter int CREDIT_W = 4
);
    logic                coin_half;
    logic                coin_one;
    logic                cancel;
    logic                drink_out_fin;
    logic                drink_en;
    logic                change_half;
    logic                coin_reject;
    logic                fault;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    // Driver side: coin mechanism, cancel button and drinkouter's finish pulse.
    modport master (
        output coin_half, coin_one, cancel, drink_out_fin,
        input  drink_en, change_half, coin_reject, fault, credit, busy
    );

    // Controller side.
    modport slave (
        input  coin_half, coin_one, cancel, drink_out_fin,
        output drink_en, change_half, coin_reject, fault, credit, busy
    );
endinterface

// File: rtl/vend_ctrl.sv
// Vending coin controller: collects half-yuan credit, enables drinkouter once the
// price is covered, then returns change one half-unit at a time. Handles cancel
// (full refund) and a dispense timeout (price refunded as change).
module vend_ctrl #(
    parameter int PRICE       = 5,
    parameter int CREDIT_W    = 4,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic         sclk,
    input  logic         srst,
    vend_ctrl_if.slave   bus
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [TW-1:0]       TMO_C   = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, COLLECT, DISPENSE, CHANGE} state_t;

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic [TW-1:0]       tmo_cnt;
    logic                drink_en_q, change_half_q, coin_reject_q, fault_q, busy_q;

    logic                any_coin;
    logic [CREDIT_W-1:0] coin_val;
    logic [TW-1:0]       tmo_nxt;

    // Coin value: half=1, one=2, both in the same cycle=3.
    assign any_coin = bus.coin_half | bus.coin_one;
    assign coin_val = CREDIT_W'({bus.coin_one, bus.coin_half});
    assign tmo_nxt  = tmo_cnt + 1'b1;

    assign bus.drink_en    = drink_en_q;
    assign bus.change_half = change_half_q;
    assign bus.coin_reject = coin_reject_q;
    assign bus.fault       = fault_q;
    assign bus.credit      = credit_q;
    assign bus.busy        = busy_q;

    // Controller FSM with all outputs registered.
    always_ff @(posedge sclk or posedge srst) begin
        if (srst) begin
            state         <= IDLE;
            credit_q      <= '0;
            tmo_cnt       <= '0;
            drink_en_q    <= 1'b0;
            change_half_q <= 1'b0;
            coin_reject_q <= 1'b0;
            fault_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            coin_reject_q <= 1'b0;
            fault_q       <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_coin) begin
                        credit_q <= coin_val;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    // Cancel beats both a same-cycle coin and the price threshold.
                    if (bus.cancel && credit_q != '0) begin
                        coin_reject_q <= any_coin;
                        busy_q        <= 1'b1;
                        state         <= CHANGE;
                    end else if (credit_q >= PRICE_C) begin
                        // Threshold uses registered credit; a coin landing now is returned.
                        coin_reject_q <= any_coin;
                        credit_q      <= credit_q - PRICE_C;
                        drink_en_q    <= 1'b1;
                        busy_q        <= 1'b1;
                        tmo_cnt       <= '0;
                        state         <= DISPENSE;
                    end else begin
                        credit_q <= credit_q + coin_val;
                    end
                end
                DISPENSE: begin
                    coin_reject_q <= any_coin;
                    if (!bus.drink_out_fin) begin
                        // Finish wins over a timeout on the same edge.
                        drink_en_q <= 1'b0;
                        if (credit_q != '0) begin
                            state <= CHANGE;
                        end else begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (tmo_nxt == TMO_C) begin
                        // Drink never delivered: refund the price along with any change.
                        drink_en_q <= 1'b0;
                        fault_q    <= 1'b1;
                        credit_q   <= credit_q + PRICE_C;
                        tmo_cnt    <= tmo_nxt;
                        state      <= CHANGE;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                    end
                end
                CHANGE: begin
                    coin_reject_q <= any_coin;
                    // Alternate high/low so pulses are spaced two cycles apart.
                    if (!change_half_q) begin
                        change_half_q <= 1'b1;
                        credit_q      <= credit_q - 1'b1;
                    end else begin
                        change_half_q <= 1'b0;
                        if (credit_q == '0) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
